cpu_writeback_queue: RTL and testbench
======================================

# cpu_writeback_queue

Parametrised successor to the single-register writeback stage. It sits between the memory stage and the register-file/commit port. Entries are accepted with the tag-change handshake and buffered in a DEPTH-entry in-order queue. They retire only when the register file is ready. Pending results stay visible on two combinational forwarding ports so decode can bypass them.

## Interface
Parameters:
- XLEN, 32, data and PC width
- TAG_W, 8, tag width
- DEPTH, 4, queue entries; power of two, ≥2

Ports:
- i_clock  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_tag  in  TAG_W  upstream tag; a value different from o_in_tag offers a new entry
- i_inst_rd  in  5  destination register index
- i_rd  in  XLEN  result value
- i_pc_next  in  XLEN  next PC of the instruction
- o_in_tag  out  TAG_W  tag of the last accepted entry; upstream holds inputs until o_in_tag == i_tag
- o_full  out  1  queue holds DEPTH entries
- o_count  out  $clog2(DEPTH)+1  current occupancy
- i_rf_ready  in  1  commit port can take a retirement this cycle
- o_tag  out  TAG_W  tag of the last retired entry
- o_inst_rd  out  5  retired destination
- o_rd  out  XLEN  retired value
- o_pc_next  out  XLEN  retired next PC
- o_rd_we  out  1  one-cycle pulse; retired entry has inst_rd ≠ 0
- i_fwd_rs1, i_fwd_rs2  in  5  lookup indices
- o_fwd_rs1_hit, o_fwd_rs2_hit  out  1  youngest pending match found
- o_fwd_rs1, o_fwd_rs2  out  XLEN  matched value; 0 when no hit

## Operation
- Accept condition: (i_tag ≠ o_in_tag) && (!o_full || retire). When it holds, the entry is written at the tail, the tail pointer increments modulo DEPTH, and o_in_tag ← i_tag.
- Retire condition: (count > 0) && i_rf_ready. When it holds:
  - head fields are copied to o_tag, o_inst_rd, o_rd and o_pc_next;
  - o_rd_we is set to 1 when inst_rd ≠ 0, otherwise 0;
  - the head pointer increments modulo DEPTH.
- When retire does not occur, o_rd_we is 0. All other outputs hold.
- Simultaneous accept and retire: count is unchanged. This is also allowed when the queue is full, since the head slot frees at the same edge.
- Count tracks occupancy, which disambiguates full from empty; pointers alone are not used for that.
- A tag equal to o_in_tag is never re-accepted. Upstream must change the tag for every instruction.
- Forwarding is combinational and checks all valid entries, youngest first. It also checks the output register while o_rd_we = 1, because that value lands in the register file only at the next edge. Index 0 never hits.
- Reset at any time (asynchronous):
  - pointers, count, o_in_tag, o_tag, o_inst_rd, o_rd, o_pc_next and o_rd_we all go to 0;
  - queued entries are discarded;
  - o_full = 0.
- Entry storage is not reset; only the valid tracking is.

## Timing
- Accept: registered at the edge where the condition is true. o_in_tag, o_count and o_full update after that edge.
- Minimum latency from tag change to o_tag change is 2 edges: accept at edge N, retire at edge N+1.
- Throughput: one entry per cycle with i_rf_ready held high.
- i_rf_ready is sampled at the edge. The retired outputs are valid from that edge until the next retirement.
- Forwarding outputs are valid in the same cycle as i_fwd_*, with no registers in the path. They reflect state after the last edge.

## Structure
- The shared package/header holds:
  - the entry field layout (tag, inst_rd, rd, pc_next);
  - the REG_ZERO = 5'd0 constant;
  - the default XLEN and TAG_W.
- One sub-module, `writeback_fifo`, holds the storage, the pointers and the count, and exposes per-slot valid/data for forwarding.
- The top level holds:
  - the tag handshake;
  - the retirement output registers;
  - the two forwarding priority searches.

## Test plan
- Reset with i_tag = 0:
  - no accept occurs;
  - all outputs are 0;
  - o_count = 0.
- Burst accept: tags 1, 2, 3 with rd = 0xA/0xB/0xC to x5/x6/x7, and i_rf_ready = 1.
  - o_tag reaches 1, 2, 3 on consecutive edges, starting 2 edges after tag 1.
  - o_rd_we pulses 3 times.
- Fill at DEPTH = 4 with i_rf_ready = 0:
  - tags 1–4 are accepted and o_full = 1;
  - tag 5 is held with o_in_tag = 4.
  - Raise i_rf_ready for one cycle: tag 1 retires, tag 5 is accepted at the same edge, and o_count stays 4.
- Forwarding:
  - queued entries x5 = 0x11 (older) and x5 = 0x22 (younger), with i_fwd_rs1 = 5, give hit = 1 and value 0x22;
  - i_fwd_rs2 = 0 gives hit = 0 and value 0;
  - during the o_rd_we pulse for x9 = 0x33 with x9 not queued, i_fwd_rs1 = 9 hits with 0x33.
- x0 write: an entry with inst_rd = 0 retires, o_tag updates, and o_rd_we stays 0.
- Asynchronous reset asserted mid-cycle with 3 entries queued:
  - outputs clear immediately, with no clock edge;
  - after release, the next new tag is accepted normally.

Source files
------------

// File: rtl/cpu_writeback_queue_pkg.sv
// cpu_writeback_queue_pkg
//   Shared definitions for the writeback queue: default widths, the
//   register-zero constant and the bit layout of one queued entry.
//   Entry layout, MSB to LSB: {tag, inst_rd, rd, pc_next}.
package cpu_writeback_queue_pkg;

   localparam int DEFAULT_XLEN  = 32;
   localparam int DEFAULT_TAG_W = 8;
   localparam int REG_IDX_W     = 5;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   // Total entry width for a given data width and tag width.
   function automatic int entry_width(input int xlen, input int tag_w);
      return tag_w + REG_IDX_W + 2 * xlen;
   endfunction

   // Field LSB positions inside a packed entry.
   function automatic int pc_next_lsb(input int xlen);
      return 0 * xlen;
   endfunction

   function automatic int rd_lsb(input int xlen);
      return xlen;
   endfunction

   function automatic int inst_rd_lsb(input int xlen);
      return 2 * xlen;
   endfunction

   function automatic int tag_lsb(input int xlen);
      return 2 * xlen + REG_IDX_W;
   endfunction

endpackage

// File: rtl/cpu_writeback_queue_fifo.sv
// writeback_fifo
//   In-order storage for the writeback queue. Holds DEPTH packed entries,
//   the head/tail pointers and an occupancy count (the count, not the
//   pointers, distinguishes full from empty). Every slot is exposed flat
//   on o_slots so the parent can run forwarding searches.
//   The parent only pushes when there is room (or a pop happens at the same
//   edge) and only pops when o_count > 0; no overflow checking is done here.
// Ports:
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_push, i_data          write i_data at the tail
//   i_pop                   advance the head
//   o_head_data, o_head_ptr oldest entry and its slot index
//   o_slots                 all slots, slot k at [k*WIDTH +: WIDTH]
//   o_count, o_full         occupancy
module writeback_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]       o_head_data,
   output logic [PTR_W-1:0]       o_head_ptr,
   output logic [DEPTH*WIDTH-1:0] o_slots,
   output logic [CNT_W-1:0]       o_count,
   output logic                   o_full
);

   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      case ({i_push, i_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (i_push) tail_reg <= tail_reg + 1'b1;
         if (i_pop)  head_reg <= head_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   // Entry storage carries no reset; validity comes from head/count only.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] data_reg;

      always_ff @(posedge i_clock) begin
         if (i_push && (tail_reg == PTR_W'(gi))) data_reg <= i_data;
      end

      assign o_slots[gi*WIDTH +: WIDTH] = data_reg;
   end

   assign o_head_data = o_slots[head_reg*WIDTH +: WIDTH];
   assign o_head_ptr  = head_reg;
   assign o_count     = count_reg;
   assign o_full      = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/cpu_writeback_queue.sv
// cpu_writeback_queue
//   Buffered writeback stage between memory and the register-file commit
//   port. New entries are offered by changing i_tag relative to o_in_tag,
//   queued in order, and retired one per cycle while i_rf_ready is high.
//   Two combinational forwarding ports return the youngest pending value
//   for a register, including the retirement register while o_rd_we is set.
// Ports:
//   i_clock, i_reset                       clock, async active-high reset
//   i_tag, i_inst_rd, i_rd, i_pc_next      incoming entry
//   o_in_tag, o_full, o_count              accept handshake / occupancy
//   i_rf_ready                             commit port ready
//   o_tag, o_inst_rd, o_rd, o_pc_next      last retired entry
//   o_rd_we                                one-cycle write pulse (rd != x0)
//   i_fwd_rs1/2, o_fwd_rs1/2_hit, o_fwd_rs1/2   forwarding lookups
module cpu_writeback_queue
   import cpu_writeback_queue_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int TAG_W = DEFAULT_TAG_W,
   parameter int DEPTH = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [TAG_W-1:0]         i_tag,
   input  logic [4:0]               i_inst_rd,
   input  logic [XLEN-1:0]          i_rd,
   input  logic [XLEN-1:0]          i_pc_next,
   output logic [TAG_W-1:0]         o_in_tag,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   input  logic                     i_rf_ready,
   output logic [TAG_W-1:0]         o_tag,
   output logic [4:0]               o_inst_rd,
   output logic [XLEN-1:0]          o_rd,
   output logic [XLEN-1:0]          o_pc_next,
   output logic                     o_rd_we,
   input  logic [4:0]               i_fwd_rs1,
   input  logic [4:0]               i_fwd_rs2,
   output logic                     o_fwd_rs1_hit,
   output logic                     o_fwd_rs2_hit,
   output logic [XLEN-1:0]          o_fwd_rs1,
   output logic [XLEN-1:0]          o_fwd_rs2
);

   localparam int ENTRY_W = entry_width(XLEN, TAG_W);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int PC_LSB  = pc_next_lsb(XLEN);
   localparam int RD_LSB  = rd_lsb(XLEN);
   localparam int IDX_LSB = inst_rd_lsb(XLEN);
   localparam int TAG_LSB = tag_lsb(XLEN);

   logic [TAG_W-1:0]         in_tag_reg;
   logic [TAG_W-1:0]         tag_reg;
   logic [4:0]               inst_rd_reg;
   logic [XLEN-1:0]          rd_reg;
   logic [XLEN-1:0]          pc_next_reg;
   logic                     rd_we_reg;

   logic                     accept;
   logic                     retire;
   logic [ENTRY_W-1:0]       push_data;
   logic [ENTRY_W-1:0]       head_data;
   logic [DEPTH*ENTRY_W-1:0] slots;
   logic [PTR_W-1:0]         head_ptr;
   logic [CNT_W-1:0]         count;
   logic                     full;

   // A full queue may still accept when the head retires at the same edge.
   assign retire    = (count != '0) && i_rf_ready;
   assign accept    = (i_tag != in_tag_reg) && (!full || retire);
   assign push_data = {i_tag, i_inst_rd, i_rd, i_pc_next};

   writeback_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (accept),
      .i_pop       (retire),
      .i_data      (push_data),
      .o_head_data (head_data),
      .o_head_ptr  (head_ptr),
      .o_slots     (slots),
      .o_count     (count),
      .o_full      (full)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         in_tag_reg <= '0;
      end else if (accept) begin
         in_tag_reg <= i_tag;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         tag_reg     <= '0;
         inst_rd_reg <= '0;
         rd_reg      <= '0;
         pc_next_reg <= '0;
         rd_we_reg   <= 1'b0;
      end else begin
         rd_we_reg <= 1'b0;
         if (retire) begin
            tag_reg     <= head_data[TAG_LSB +: TAG_W];
            inst_rd_reg <= head_data[IDX_LSB +: REG_IDX_W];
            rd_reg      <= head_data[RD_LSB +: XLEN];
            pc_next_reg <= head_data[PC_LSB +: XLEN];
            rd_we_reg   <= (head_data[IDX_LSB +: REG_IDX_W] != REG_ZERO);
         end
      end
   end

   // Forwarding: walk from oldest to youngest so the last match wins. The
   // retirement register is older than anything still queued, so it is
   // checked first and any queued match overrides it.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0]       idx;
      logic             hit;
      logic [XLEN-1:0]  val;
      logic [PTR_W-1:0] age_idx;

      assign idx = (gi == 0) ? i_fwd_rs1 : i_fwd_rs2;

      always_comb begin
         hit     = 1'b0;
         val     = '0;
         age_idx = '0;
         if (idx != REG_ZERO) begin
            if (rd_we_reg && (inst_rd_reg == idx)) begin
               hit = 1'b1;
               val = rd_reg;
            end
            for (int k = 0; k < DEPTH; k++) begin
               age_idx = head_ptr + PTR_W'(k);
               if ((CNT_W'(k) < count) &&
                   (slots[age_idx*ENTRY_W + IDX_LSB +: REG_IDX_W] == idx)) begin
                  hit = 1'b1;
                  val = slots[age_idx*ENTRY_W + RD_LSB +: XLEN];
               end
            end
         end
      end
   end

   assign o_in_tag      = in_tag_reg;
   assign o_full        = full;
   assign o_count       = count;
   assign o_tag         = tag_reg;
   assign o_inst_rd     = inst_rd_reg;
   assign o_rd          = rd_reg;
   assign o_pc_next     = pc_next_reg;
   assign o_rd_we       = rd_we_reg;
   assign o_fwd_rs1_hit = g_fwd[0].hit;
   assign o_fwd_rs1     = g_fwd[0].val;
   assign o_fwd_rs2_hit = g_fwd[1].hit;
   assign o_fwd_rs2     = g_fwd[1].val;

endmodule

// File: tb/tb_cpu_writeback_queue.sv
// tb_cpu_writeback_queue
//   Directed bench for cpu_writeback_queue (XLEN=32, TAG_W=8, DEPTH=4).
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_cpu_writeback_queue;

   logic        i_clock;
   logic        i_reset;
   logic [7:0]  i_tag;
   logic [4:0]  i_inst_rd;
   logic [31:0] i_rd;
   logic [31:0] i_pc_next;
   logic [7:0]  o_in_tag;
   logic        o_full;
   logic [2:0]  o_count;
   logic        i_rf_ready;
   logic [7:0]  o_tag;
   logic [4:0]  o_inst_rd;
   logic [31:0] o_rd;
   logic [31:0] o_pc_next;
   logic        o_rd_we;
   logic [4:0]  i_fwd_rs1;
   logic [4:0]  i_fwd_rs2;
   logic        o_fwd_rs1_hit;
   logic        o_fwd_rs2_hit;
   logic [31:0] o_fwd_rs1;
   logic [31:0] o_fwd_rs2;

   int n_checks;
   int n_pass;

   cpu_writeback_queue #(
      .XLEN  (32),
      .TAG_W (8),
      .DEPTH (4)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_tag         (i_tag),
      .i_inst_rd     (i_inst_rd),
      .i_rd          (i_rd),
      .i_pc_next     (i_pc_next),
      .o_in_tag      (o_in_tag),
      .o_full        (o_full),
      .o_count       (o_count),
      .i_rf_ready    (i_rf_ready),
      .o_tag         (o_tag),
      .o_inst_rd     (o_inst_rd),
      .o_rd          (o_rd),
      .o_pc_next     (o_pc_next),
      .o_rd_we       (o_rd_we),
      .i_fwd_rs1     (i_fwd_rs1),
      .i_fwd_rs2     (i_fwd_rs2),
      .o_fwd_rs1_hit (o_fwd_rs1_hit),
      .o_fwd_rs2_hit (o_fwd_rs2_hit),
      .o_fwd_rs1     (o_fwd_rs1),
      .o_fwd_rs2     (o_fwd_rs2)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-22s got 0x%0h", tag, got);
      end else begin
         $display("FAIL %-22s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
   endtask

   // Present an entry and clock once; caller checks the outcome.
   task automatic offer(input logic [7:0] tag, input logic [4:0] rd_idx,
                        input logic [31:0] val);
      i_tag     = tag;
      i_inst_rd = rd_idx;
      i_rd      = val;
      i_pc_next = 32'h1000 + {24'h0, tag} * 4;
      step();
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      i_reset    = 1'b1;
      i_tag      = '0;
      i_inst_rd  = '0;
      i_rd       = '0;
      i_pc_next  = '0;
      i_rf_ready = 1'b0;
      i_fwd_rs1  = '0;
      i_fwd_rs2  = '0;

      // ---- reset state, tag 0 must not be accepted ----
      step();
      step();
      i_reset = 1'b0;
      step();
      check("rst_in_tag", o_in_tag, 0);
      check("rst_count", o_count, 0);
      check("rst_full", o_full, 0);
      check("rst_tag", o_tag, 0);
      check("rst_rd", o_rd, 0);
      check("rst_rd_we", o_rd_we, 0);
      check("rst_fwd1_hit", o_fwd_rs1_hit, 0);

      // ---- burst: tags 1,2,3 with rf ready ----
      i_rf_ready = 1'b1;
      offer(8'd1, 5'd5, 32'hA);
      check("burst_acc1_in_tag", o_in_tag, 1);
      check("burst_acc1_tag", o_tag, 0);
      check("burst_acc1_count", o_count, 1);
      offer(8'd2, 5'd6, 32'hB);
      check("burst_ret1_tag", o_tag, 1);
      check("burst_ret1_rd", o_rd, 32'hA);
      check("burst_ret1_inst_rd", o_inst_rd, 5);
      check("burst_ret1_pc", o_pc_next, 32'h1004);
      check("burst_ret1_we", o_rd_we, 1);
      offer(8'd3, 5'd7, 32'hC);
      check("burst_ret2_tag", o_tag, 2);
      check("burst_ret2_rd", o_rd, 32'hB);
      check("burst_ret2_we", o_rd_we, 1);
      check("burst_ret2_count", o_count, 1);
      step();
      check("burst_ret3_tag", o_tag, 3);
      check("burst_ret3_rd", o_rd, 32'hC);
      check("burst_ret3_we", o_rd_we, 1);
      check("burst_ret3_count", o_count, 0);
      step();
      check("burst_idle_we", o_rd_we, 0);
      check("burst_idle_tag", o_tag, 3);

      // ---- fill to DEPTH with rf not ready ----
      i_rf_ready = 1'b0;
      do_reset();
      for (int t = 1; t <= 4; t++) offer(8'(t), 5'(t), 32'h10 + 32'(t));
      check("fill_count", o_count, 4);
      check("fill_full", o_full, 1);
      check("fill_in_tag", o_in_tag, 4);
      offer(8'd5, 5'd5, 32'h15);
      check("fill_held_in_tag", o_in_tag, 4);
      check("fill_held_count", o_count, 4);
      check("fill_held_tag", o_tag, 0);
      i_rf_ready = 1'b1;
      step();
      i_rf_ready = 1'b0;
      check("fill_swap_tag", o_tag, 1);
      check("fill_swap_rd", o_rd, 32'h11);
      check("fill_swap_in_tag", o_in_tag, 5);
      check("fill_swap_count", o_count, 4);
      check("fill_swap_full", o_full, 1);
      step();
      check("fill_after_we", o_rd_we, 0);
      check("fill_after_tag", o_tag, 1);

      // ---- forwarding: youngest wins, index 0 never hits ----
      do_reset();
      offer(8'd1, 5'd5, 32'h11);
      offer(8'd2, 5'd5, 32'h22);
      i_fwd_rs1 = 5'd5;
      i_fwd_rs2 = 5'd0;
      #1;
      check("fwd_young_hit", o_fwd_rs1_hit, 1);
      check("fwd_young_val", o_fwd_rs1, 32'h22);
      check("fwd_x0_hit", o_fwd_rs2_hit, 0);
      check("fwd_x0_val", o_fwd_rs2, 0);
      i_fwd_rs2 = 5'd6;
      #1;
      check("fwd_miss_hit", o_fwd_rs2_hit, 0);
      check("fwd_miss_val", o_fwd_rs2, 0);

      // ---- forwarding from the retirement register ----
      do_reset();
      i_fwd_rs1 = 5'd9;
      offer(8'd1, 5'd9, 32'h33);
      i_rf_ready = 1'b1;
      step();
      i_rf_ready = 1'b0;
      check("fwd_out_we", o_rd_we, 1);
      check("fwd_out_count", o_count, 0);
      check("fwd_out_hit", o_fwd_rs1_hit, 1);
      check("fwd_out_val", o_fwd_rs1, 32'h33);
      step();
      check("fwd_out_gone_hit", o_fwd_rs1_hit, 0);

      // ---- x0 destination: retires without a write pulse ----
      offer(8'd2, 5'd0, 32'h44);
      i_rf_ready = 1'b1;
      step();
      i_rf_ready = 1'b0;
      check("x0_tag", o_tag, 2);
      check("x0_rd", o_rd, 32'h44);
      check("x0_we", o_rd_we, 0);

      // ---- async reset mid-cycle with 3 entries queued ----
      do_reset();
      for (int t = 1; t <= 4; t++) offer(8'(t), 5'(t), 32'h20 + 32'(t));
      i_rf_ready = 1'b1;
      step();
      i_rf_ready = 1'b0;
      check("areset_pre_count", o_count, 3);
      check("areset_pre_tag", o_tag, 1);
      #2;
      i_reset = 1'b1;
      #1;
      check("areset_count", o_count, 0);
      check("areset_in_tag", o_in_tag, 0);
      check("areset_tag", o_tag, 0);
      check("areset_rd", o_rd, 0);
      check("areset_pc", o_pc_next, 0);
      check("areset_we", o_rd_we, 0);
      check("areset_full", o_full, 0);
      #1;
      i_reset = 1'b0;
      i_fwd_rs1 = 5'd3;
      i_fwd_rs2 = 5'd2;
      offer(8'd7, 5'd3, 32'h55);
      check("areset_new_in_tag", o_in_tag, 7);
      check("areset_new_count", o_count, 1);
      check("areset_new_fwd_hit", o_fwd_rs1_hit, 1);
      check("areset_new_fwd_val", o_fwd_rs1, 32'h55);
      check("areset_old_discard", o_fwd_rs2_hit, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
